// File: rtl/prog_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// prog_fetch_unit_if
//
// Bundles every non-clock/reset signal of the instruction fetch sequencer.
//   ROM side     : rom_addr, set_addr, en_data (driven by the fetch unit),
//                  rom_data, noi (driven by the ROM).
//   Consumer side: instr_valid, opcode, operand, two_byte, instr_pc, halted
//                  (driven by the fetch unit), instr_ready (driven by decode).
//   Control      : run (fetch enable), branch_en/branch_addr (redirect from
//                  execute).
//
// Modports:
//   master - the fetch unit itself.
//   slave  - the surrounding system (ROM + decode/execute).
// -----------------------------------------------------------------------------
interface prog_fetch_unit_if;
  logic       run;
  logic [7:0] noi;
  logic [7:0] rom_data;
  logic [7:0] rom_addr;
  logic       set_addr;
  logic       en_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic       two_byte;
  logic [7:0] instr_pc;
  logic       branch_en;
  logic [7:0] branch_addr;
  logic       halted;

  modport master (
    input  run, noi, rom_data, instr_ready, branch_en, branch_addr,
    output rom_addr, set_addr, en_data, instr_valid, opcode, operand,
           two_byte, instr_pc, halted
  );

  modport slave (
    output run, noi, rom_data, instr_ready, branch_en, branch_addr,
    input  rom_addr, set_addr, en_data, instr_valid, opcode, operand,
           two_byte, instr_pc, halted
  );
endinterface

// File: rtl/prog_fetch_unit.sv
// -----------------------------------------------------------------------------
// prog_fetch_unit
//
// Instruction fetch sequencer sitting in front of the program ROM. It walks
// the program counter through the ROM, fetching an opcode byte and, for
// opcodes whose high nibble is flagged in TWO_BYTE_MASK, an operand byte.
// Each assembled instruction is offered to decode with a valid/ready
// handshake. Execute may redirect the PC at any time with branch_en; the unit
// halts once the PC reaches the program length noi.
//
// Ports:
//   clk    - system clock, rising edge active.
//   reset  - asynchronous, active-high reset.
//   bus    - prog_fetch_unit_if.master (ROM strobes, instruction handshake,
//            run / branch control, halted status).
//
// Parameters:
//   TWO_BYTE_MASK - bit n set: opcodes with high nibble n carry an operand.
//
// Strobe timing: set_addr and en_data are decoded from the current state, so
// an ADDR_* state presents the address and the following READ_* state reads
// the byte. rom_addr is held in a register whenever set_addr is low.
// -----------------------------------------------------------------------------
module prog_fetch_unit #(
  parameter logic [15:0] TWO_BYTE_MASK = 16'h0034
) (
  input logic          clk,
  input logic          reset,
  prog_fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    ADDR_OP,
    READ_OP,
    ADDR_ARG,
    READ_ARG,
    ISSUE,
    HALT
  } state_t;

  state_t     state_q,    state_d;
  logic [7:0] pc_q,       pc_d;
  logic [7:0] opcode_q,   opcode_d;
  logic [7:0] operand_q,  operand_d;
  logic       two_byte_q, two_byte_d;
  logic [7:0] instr_pc_q, instr_pc_d;
  logic [7:0] rom_addr_q;

  logic       set_addr;
  logic       en_data;
  logic       instr_valid;
  logic       halted;
  logic [7:0] rom_addr;

  // ---------------------------------------------------------------------------
  // Next-state and strobe decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    opcode_d    = opcode_q;
    operand_d   = operand_q;
    two_byte_d  = two_byte_q;
    instr_pc_d  = instr_pc_q;
    set_addr    = 1'b0;
    en_data     = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;

    unique case (state_q)
      ADDR_OP: begin
        // The noi bound is checked before run so a finished program halts
        // even while fetch is disabled.
        if (pc_q >= bus.noi) begin
          state_d = HALT;
        end else if (bus.run) begin
          set_addr   = 1'b1;
          instr_pc_d = pc_q;
          state_d    = READ_OP;
        end
      end

      READ_OP: begin
        en_data    = 1'b1;
        opcode_d   = bus.rom_data;
        operand_d  = 8'h00;
        pc_d       = pc_q + 8'd1;
        two_byte_d = TWO_BYTE_MASK[bus.rom_data[7:4]];
        state_d    = TWO_BYTE_MASK[bus.rom_data[7:4]] ? ADDR_ARG : ISSUE;
      end

      // The operand byte is fetched even if pc has just reached noi.
      ADDR_ARG: begin
        set_addr = 1'b1;
        state_d  = READ_ARG;
      end

      READ_ARG: begin
        en_data   = 1'b1;
        operand_d = bus.rom_data;
        pc_d      = pc_q + 8'd1;
        state_d   = ISSUE;
      end

      ISSUE: begin
        instr_valid = 1'b1;
        if (bus.instr_ready) begin
          state_d = ADDR_OP;
        end
      end

      HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = ADDR_OP;
      end
    endcase

    // A redirect overrides whatever the state machine decided: the fetch in
    // flight is dropped (no capture, no increment, no ROM strobe) and the
    // next cycle starts an opcode fetch at the target. An ISSUE handshake in
    // the same cycle still completes because instr_valid is left alone.
    if (bus.branch_en) begin
      pc_d       = bus.branch_addr;
      state_d    = ADDR_OP;
      opcode_d   = opcode_q;
      operand_d  = operand_q;
      two_byte_d = two_byte_q;
      instr_pc_d = instr_pc_q;
      set_addr   = 1'b0;
      en_data    = 1'b0;
    end

    // Reset parks the FSM in ADDR_OP, which would otherwise raise set_addr
    // while reset is still asserted; keep the ROM quiet until release.
    if (reset) begin
      set_addr = 1'b0;
      en_data  = 1'b0;
    end
  end

  // rom_addr follows pc while an address is being presented and otherwise
  // repeats the last presented address.
  assign rom_addr = set_addr ? pc_q : rom_addr_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: all of these are control/datapath flops and every one has a defined
  // reset value; there is no memory array here to leave uninitialised.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ADDR_OP;
      pc_q       <= 8'h00;
      opcode_q   <= 8'h00;
      operand_q  <= 8'h00;
      two_byte_q <= 1'b0;
      instr_pc_q <= 8'h00;
      rom_addr_q <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q    <= state_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      two_byte_q <= two_byte_d;
      instr_pc_q <= instr_pc_d;
      rom_addr_q <= rom_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.rom_addr    = rom_addr;
  assign bus.set_addr    = set_addr;
  assign bus.en_data     = en_data;
  assign bus.instr_valid = instr_valid;
  assign bus.opcode      = opcode_q;
  assign bus.operand     = operand_q;
  assign bus.two_byte    = two_byte_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.halted      = halted;

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  // The ROM cannot latch an address and drive data in the same cycle.
  a_strobe_exclusive : assert property (
    @(posedge clk) disable iff (reset) !(set_addr && en_data)
  );

  // A pending instruction stays put until decode takes it or a redirect
  // discards it.
  a_issue_stable : assert property (
    @(posedge clk) disable iff (reset)
    (instr_valid && !bus.instr_ready && !bus.branch_en) |=>
      (instr_valid && $stable(opcode_q) && $stable(operand_q) &&
       $stable(two_byte_q) && $stable(instr_pc_q))
  );

endmodule
